// File: rtl/violation_reset_ctrl.sv
// Violation reset sequencer: turns monitor violation flags into a held CPU reset.
// It records the sticky cause and a saturating episode count, both cleared only by por.
module violation_reset_ctrl #(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          HOLD_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        por,
    input  logic [15:0] pc,
    input  logic [5:0]  viol,
    input  logic        cause_clr,
    output logic        reset,
    output logic [5:0]  cause,
    output logic [7:0]  viol_cnt,
    output logic        busy
);

    // Out-of-range hold lengths collapse to a single hold cycle.
    localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES >= 1 && HOLD_CYCLES <= 15)
                                       ? 4'(HOLD_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  hold_cnt_q;
    logic [5:0]  cause_q;
    logic [7:0]  viol_cnt_q;
    logic [7:0]  viol_cnt_d;
    logic [5:0]  cause_acc_d;
    logic        viol_any_s;

    // Saturating episode count and cause accumulation for the sequencer below.
    always_comb begin
        viol_any_s  = (viol != 6'd0);
        cause_acc_d = cause_q | viol;
        if (viol_cnt_q != 8'hFF) begin
            viol_cnt_d = viol_cnt_q + 8'd1;
        end else begin
            viol_cnt_d = viol_cnt_q;
        end
    end

    // Episode sequencer: IDLE -> HOLD (fixed length) -> WAIT (until handler re-entry).
    always_ff @(posedge clk or posedge por) begin
        if (por) begin
            state_q    <= IDLE;
            hold_cnt_q <= 4'd0;
            cause_q    <= 6'd0;
            viol_cnt_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (viol_any_s) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= HOLD_LOAD;
                        cause_q    <= viol;
                        viol_cnt_q <= viol_cnt_d;
                    end else if (cause_clr) begin
                        cause_q <= 6'd0;
                    end else begin
                        cause_q <= cause_q;
                    end
                end
                HOLD: begin
                    cause_q <= cause_acc_d;
                    if (hold_cnt_q == 4'd0) begin
                        state_q <= WAIT;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 4'd1;
                    end
                end
                WAIT: begin
                    // A violation on the exit edge is only recorded; it must persist to restart.
                    cause_q <= cause_acc_d;
                    if (pc == RESET_HANDLER) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    hold_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign reset    = (state_q != IDLE);
    assign busy     = (state_q != IDLE);
    assign cause    = cause_q;
    assign viol_cnt = viol_cnt_q;

endmodule

// File: doc/violation_reset_ctrl.md
VIOLATION_RESET_CTRL -- requirements
Module: violation_reset_ctrl

Interface
REQ-001 SHALL have parameter RESET_HANDLER, default 16'h0000: PC value that marks re-entry to the reset handler.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, 4-bit: reset hold length in cycles; legal range 1-15.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  system clock; all state on rising edge.
REQ-005 Port: por  input  1  power-on reset; asynchronous, active-high.
REQ-006 Port: pc  input  16  current CPU program counter.
REQ-007 Port: viol  input  6  monitor violation flags, bit order [0]=X_stack, [1]=AC, [2]=atomicity, [3]=dma_AC, [4]=dma_detect, [5]=dma_X_stack.
REQ-008 Port: cause_clr  input  1  software request to clear the cause register.
REQ-009 Port: reset  output  1  sequenced violation reset to the CPU.
REQ-010 Port: cause  output  6  sticky record of violation flags that caused the current or last reset.
REQ-011 Port: viol_cnt  output  8  count of reset episodes since por.
REQ-012 Port: busy  output  1  high while a reset episode is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, HOLD and WAIT.
REQ-014 reset and busy SHALL both equal (state != IDLE), decoded from registered state with no combinational path from viol.
REQ-015 IDLE: if viol != 0 at a rising edge, next state SHALL be HOLD; reset rises 1 cycle after the violation is sampled.
REQ-016 On IDLE->HOLD: load cause with viol and load hold counter with HOLD_CYCLES-1.
REQ-017 On IDLE->HOLD: increment viol_cnt by 1, saturating at 8'hFF (no wrap).
REQ-018 HOLD: counter == 0 -> WAIT; otherwise decrement and stay. HOLD SHALL last exactly HOLD_CYCLES cycles.
REQ-019 WAIT: pc == RESET_HANDLER sampled at an edge -> IDLE; otherwise stay in WAIT with reset held high, no timeout.
REQ-020 Minimum reset pulse SHALL be HOLD_CYCLES+1 cycles.
REQ-021 Violations in HOLD or WAIT: OR into cause; no viol_cnt increment, no counter reload, no state change.
REQ-022 In the cycle WAIT->IDLE, an asserted viol is ORed into cause only; it starts a new episode only if still asserted in IDLE on the next edge.
REQ-023 cause_clr SHALL clear cause only when state == IDLE and viol == 0.
REQ-024 cause_clr with viol != 0 in IDLE: the violation wins, cause <= viol.
REQ-025 cause_clr in HOLD or WAIT SHALL be ignored.
REQ-026 cause_clr SHALL NOT affect viol_cnt.
REQ-027 cause and viol_cnt SHALL hold their values across the violation reset; only por clears them.
REQ-028 HOLD_CYCLES outside 1-15 SHALL be treated as 1.

Reset
REQ-029 por high SHALL asynchronously force state IDLE, hold counter 0, cause 6'b0, viol_cnt 8'h00, reset 0, busy 0.
REQ-030 por asserted mid-episode SHALL abort the episode immediately, deasserting reset within the same cycle.
REQ-031 After por deasserts, the first violation SHALL be accepted at the next rising edge.

Verification
REQ-032 HOLD_CYCLES=4, viol=6'b000010 pulsed 1 cycle at edge 0, pc==0 from edge 3 -> reset high edges 1-6, busy mirrors it, cause=6'b000010, viol_cnt=1, IDLE at edge 6.
REQ-033 HOLD_CYCLES=4, viol=6'b000001 at edge 0, viol=6'b100000 at edge 2, pc != 0 until edge 10 -> reset high edges 1-11, cause=6'b100001, viol_cnt=1.
REQ-034 IDLE with cause=6'b000100: cause_clr together with viol=6'b001000 -> cause=6'b001000, new episode, viol_cnt incremented; cause_clr alone in a later IDLE cycle -> cause=0.
REQ-035 256 back-to-back episodes -> viol_cnt saturates at 8'hFF; the 257th episode leaves it at 8'hFF while reset still sequences normally.
REQ-036 por asserted during HOLD at cycle 2 -> reset 0 asynchronously, cause=0, viol_cnt=0; violation at the first edge after por release -> reset high at the next edge.
REQ-037 viol held high continuously with pc==RESET_HANDLER -> repeated episodes, each with reset high HOLD_CYCLES+1 cycles, separated by exactly 1 IDLE cycle; viol_cnt increments once per episode.
